// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier controller driving an external WIDTH-bit adder.
// Optional macro MULT_ZERO_SKIP_EN: zero operands go straight to DONE with product 0.
module mult_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     adder_a,
  output logic [WIDTH-1:0]     adder_m,
  input  logic [WIDTH-1:0]     adder_sum,
  input  logic                 adder_carry,
  output logic [1:0]           fsm_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  q_reg;
  logic [WIDTH-1:0]  m_reg;
  logic              c_reg;
  logic [CW-1:0]     count;
  logic              last_bit;
  logic              zero_op;
  logic [2*WIDTH:0]  shifted;

  // Handshake: a request is taken on any rising edge where start=1 and ready=1;
  // done is a single-cycle pulse and product stays valid until the next accepted start.

`ifdef MULT_ZERO_SKIP_EN
  assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign last_bit = (count == LAST);
  // Logical right shift of {C,A,Q}; the top bit of the result is always zero.
  assign shifted  = {c_reg, a_reg, q_reg} >> 1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = zero_op ? DONE : ADD;
      ADD:     state_next = SHIFT;
      SHIFT:   state_next = last_bit ? DONE : ADD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      a_reg   <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
      c_reg   <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= zero_op ? '0 : multiplier;
            a_reg <= '0;
            c_reg <= 1'b0;
            count <= '0;
            if (zero_op) product <= '0;
          end
        end
        ADD: begin
          if (q_reg[0]) begin
            a_reg <= adder_sum;
            c_reg <= adder_carry;
          end else begin
            c_reg <= 1'b0;
          end
        end
        SHIFT: begin
          c_reg <= shifted[2*WIDTH];
          a_reg <= shifted[2*WIDTH-1:WIDTH];
          q_reg <= shifted[WIDTH-1:0];
          if (last_bit) product <= shifted[2*WIDTH-1:0];
          else          count   <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state == IDLE);
  assign done      = (state == DONE);
  assign adder_a   = a_reg;
  assign adder_m   = m_reg;
  assign fsm_state = state;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: driver pushes a*m and the due cycle, monitor pops on done.
module tb_mult_seq_ctrl;
  localparam int W = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           ready;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   adder_a;
  logic [W-1:0]   adder_m;
  logic [W-1:0]   adder_sum;
  logic           adder_carry;
  logic [1:0]     fsm_state;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .ready(ready), .done(done), .product(product),
    .adder_a(adder_a), .adder_m(adder_m),
    .adder_sum(adder_sum), .adder_carry(adder_carry),
    .fsm_state(fsm_state)
  );

  // Behavioural stand-in for the shared 4-bit adder.
  assign {adder_carry, adder_sum} = {1'b0, adder_a} + {1'b0, adder_m};

  always #5 clock = ~clock;

  int             cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [2*W-1:0] exp_q[$];
  int             due_q[$];
  logic [2*W-1:0] last_prod;
  bit             mon_en = 1'b0;
  int             vectors = 0;
  int             miscompares = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int latency(input logic [W-1:0] a, input logic [W-1:0] m);
`ifdef MULT_ZERO_SKIP_EN
    if (a == 0 || m == 0) return 0;
`endif
    return 2 * W;
  endfunction

  // Monitor: every cycle checks done/ready against the model, and product on done or hold.
  always @(negedge clock) begin
    if (mon_en) begin
      bit exp_done;
      exp_done = (exp_q.size() > 0) && (cyc == due_q[0]);
      chk("done", {15'd0, done}, {15'd0, exp_done});
      chk("ready", {15'd0, ready}, {15'd0, (exp_q.size() == 0)});
      if (exp_done) begin
        last_prod = exp_q.pop_front();
        void'(due_q.pop_front());
        chk("product", {8'd0, product}, {8'd0, last_prod});
      end else begin
        chk("product_hold", {8'd0, product}, {8'd0, last_prod});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] m);
    int t = 0;
    while (!ready && t < 40) begin
      @(posedge clock); #1;
      t++;
    end
    if (!ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout at cycle %0d: got 0 expected 1", cyc);
      return;
    end
    start = 1'b1;
    multiplicand = a;
    multiplier = m;
    @(posedge clock); #1;
    start = 1'b0;
    multiplicand = W'($urandom);
    multiplier = W'($urandom);
    exp_q.push_back((2*W)'(a) * (2*W)'(m));
    due_q.push_back(cyc + latency(a, m));
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() > 0 || !ready) && t < 40) begin
      @(posedge clock); #1;
      t++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout at cycle %0d: got pending %0d expected 0", cyc, exp_q.size());
      exp_q.delete();
      due_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d: got running expected finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_ready", {15'd0, ready}, 16'd1);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_product", {8'd0, product}, 16'd0);
    chk("rst_adder_a", {12'd0, adder_a}, 16'd0);
    chk("rst_adder_m", {12'd0, adder_m}, 16'd0);
    last_prod = '0;
    mon_en = 1'b1;

    // Largest operands: 225.
    start_op(4'd15, 4'd15);
    wait_idle();

    // Zero operands.
    start_op(4'd9, 4'd0);
    wait_idle();
    start_op(4'd0, 4'd13);
    wait_idle();

    // Start during SHIFT is ignored.
    start_op(4'd12, 4'd11);
    @(posedge clock); #1;
    start = 1'b1;
    multiplicand = 4'd3;
    multiplier = 4'd3;
    @(posedge clock); #1;
    start = 1'b0;
    wait_idle();
    start_op(4'd3, 4'd3);
    wait_idle();

    // Reset mid-operation aborts without a done pulse.
    start_op(4'd7, 4'd6);
    repeat (3) begin
      @(posedge clock); #1;
    end
    mon_en = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    due_q.delete();
    last_prod = '0;
    chk("abort_ready", {15'd0, ready}, 16'd1);
    chk("abort_done", {15'd0, done}, 16'd0);
    chk("abort_product", {8'd0, product}, 16'd0);
    mon_en = 1'b1;
    start_op(4'd7, 4'd6);
    wait_idle();

    // Adder ports are the registered A and M during the first ADD.
    start_op(4'd1, 4'd1);
    chk("first_add_adder_a", {12'd0, adder_a}, 16'd0);
    chk("first_add_adder_m", {12'd0, adder_m}, 16'd1);
    wait_idle();
    repeat (5) begin
      @(posedge clock); #1;
    end
    chk("product_idle_hold", {8'd0, product}, 16'd1);

    // Exhaustive, back-to-back.
    for (int a = 0; a < 16; a++) begin
      for (int m = 0; m < 16; m++) begin
        start_op(W'(a), W'(m));
      end
    end
    wait_idle();

    // Random operands with random idle gaps.
    for (int i = 0; i < 60; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clock); #1;
      end
      start_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    end
    wait_idle();
    repeat (3) begin
      @(posedge clock); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
